// File: rtl/lieat_csa_resolve.sv
// Resolves a carry-save pair into a binary sum. The sum is formed by a multi-cycle ripple of CHUNK-bit slices, LSB first.
// Latency is WIDTH/CHUNK cycles from accept to out_valid; out_valid holds, with the result stable, until out_ready is seen.
module lieat_csa_resolve #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sum_i,
    input  logic [WIDTH-1:0] carry_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result_o,
    output logic             cout_o
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCH - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] carry_q;
    logic [IW-1:0]    idx;
    logic             rc;
    logic [CHUNK-1:0] slice_a;
    logic [CHUNK-1:0] slice_b;
    logic [CHUNK:0]   slice_sum;

    always_comb begin
        slice_a   = sum_q[int'(idx)*CHUNK +: CHUNK];
        slice_b   = carry_q[int'(idx)*CHUNK +: CHUNK];
        slice_sum = {1'b0, slice_a} + {1'b0, slice_b} + {{CHUNK{1'b0}}, rc};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result_o  <= '0;
            cout_o    <= 1'b0;
            sum_q     <= '0;
            carry_q   <= '0;
            idx       <= '0;
            rc        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sum_q    <= sum_i;
                        carry_q  <= carry_i;
                        idx      <= '0;
                        rc       <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= ADD;
                    end
                end
                ADD: begin
                    result_o[int'(idx)*CHUNK +: CHUNK] <= slice_sum[CHUNK-1:0];
                    rc <= slice_sum[CHUNK];
                    if (idx == LAST) begin
                        cout_o    <= slice_sum[CHUNK];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    // Returning to IDLE here keeps accept out of the DONE cycle.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lieat_csa_resolve.sv
// Bench for lieat_csa_resolve: directed cases plus a randomized scoreboard.
// The scoreboard is checked against a plain 33-bit addition model.
module tb_lieat_csa_resolve;

    localparam int WIDTH = 32;
    localparam int CHUNK = 8;
    localparam int LAT   = WIDTH / CHUNK;
    localparam int NRAND = 3000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] sum_i = '0;
    logic [WIDTH-1:0] carry_i = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] result_o;
    logic             cout_o;

    int tests = 0;
    int fails = 0;

    lieat_csa_resolve #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .sum_i(sum_i), .carry_i(carry_i), .out_valid(out_valid),
        .out_ready(out_ready), .result_o(result_o), .cout_o(cout_o)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH:0] ref_sum(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one pair and returns one step after the accepting edge, with inputs scrambled.
    task automatic start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (in_ready) ok = 1'b1;
            else tick();
        end
        if (ok) begin
            in_valid = 1'b1;
            sum_i    = a;
            carry_i  = b;
            tick();
            in_valid = 1'b0;
            sum_i    = $urandom;
            carry_i  = $urandom;
        end
    endtask

    task automatic wait_valid(output int cyc);
        bit seen;
        seen = 1'b0;
        cyc  = -1;
        for (int i = 1; i <= 20 && !seen; i++) begin
            tick();
            if (out_valid) begin
                seen = 1'b1;
                cyc  = i;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result_o !== '0 || cout_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: rdy=%b vld=%b res=%h cout=%b required 1 0 0 0",
                     in_ready, out_valid, result_o, cout_o);
        end
        rst_n = 1'b1;
    endtask

    task automatic run_simple(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bit ok;
        int cyc;
        logic [WIDTH:0] exp;
        exp = ref_sum(a, b);
        out_ready = 1'b1;
        start(a, b, ok);
        tests++;
        if (!ok || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL %s_accept: ok=%0d in_ready=%b required accepted with in_ready=0", name, ok, in_ready);
        end
        wait_valid(cyc);
        tests++;
        if (cyc != LAT) begin
            fails++;
            $display("FAIL %s_latency: got %0d cycles required %0d", name, cyc, LAT);
        end
        tests++;
        if ({cout_o, result_o} !== exp) begin
            fails++;
            $display("FAIL %s_result: got %b_%h required %b_%h", name, cout_o, result_o, exp[WIDTH], exp[WIDTH-1:0]);
        end
        tick();
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s_idle: rdy=%b vld=%b required 1 0", name, in_ready, out_valid);
        end
    endtask

    task automatic test_basic();
        run_simple("basic", 32'h0000_1234, 32'h0000_0F0E);
    endtask

    task automatic test_wrap();
        run_simple("wrap", 32'hFFFF_FFFF, 32'h0000_0001);
    endtask

    task automatic test_stall();
        bit ok;
        int cyc;
        out_ready = 1'b0;
        start(32'h8000_0000, 32'h8000_0000, ok);
        wait_valid(cyc);
        tests++;
        if (!ok || cyc != LAT) begin
            fails++;
            $display("FAIL stall_latency: got %0d cycles required %0d", cyc, LAT);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if (out_valid !== 1'b1 || result_o !== '0 || cout_o !== 1'b1) begin
                fails++;
                $display("FAIL stall_hold: cycle %0d vld=%b res=%h cout=%b required 1 0 1", i, out_valid, result_o, cout_o);
            end
        end
        out_ready = 1'b1;
        tick();
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL stall_release: rdy=%b vld=%b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_ignore_busy();
        bit ok;
        int cyc;
        logic [WIDTH-1:0] a1, b1, a2, b2;
        logic [WIDTH:0] exp1, exp2;
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
        exp1 = ref_sum(a1, b1);
        exp2 = ref_sum(a2, b2);
        out_ready = 1'b0;
        start(a1, b1, ok);
        for (int c = 1; c <= 6; c++) begin
            in_valid = 1'b1;
            sum_i    = $urandom;
            carry_i  = $urandom;
            tick();
            tests++;
            if (out_valid !== (c >= LAT)) begin
                fails++;
                $display("FAIL busy_valid: cycle %0d vld=%b required %b", c, out_valid, c >= LAT);
            end
        end
        tests++;
        if ({cout_o, result_o} !== exp1) begin
            fails++;
            $display("FAIL busy_result: got %b_%h required %b_%h", cout_o, result_o, exp1[WIDTH], exp1[WIDTH-1:0]);
        end
        in_valid  = 1'b1;
        sum_i     = a2;
        carry_i   = b2;
        out_ready = 1'b1;
        tick();
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL busy_no_passthru: in_ready=%b required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        sum_i    = $urandom;
        carry_i  = $urandom;
        wait_valid(cyc);
        tests++;
        if (cyc != LAT || {cout_o, result_o} !== exp2) begin
            fails++;
            $display("FAIL busy_second: cyc=%0d got %b_%h required %0d %b_%h", cyc, cout_o, result_o,
                     LAT, exp2[WIDTH], exp2[WIDTH-1:0]);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bit ok;
        int cyc;
        logic [WIDTH-1:0] a, b;
        logic [WIDTH:0] exp;
        out_ready = 1'b1;
        start(32'hDEAD_BEEF, 32'h1111_1111, ok);
        tick();
        rst_n = 1'b0;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL midreset_pre: vld=%b required 0", out_valid);
        end
        tick();
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result_o !== '0 || cout_o !== 1'b0) begin
            fails++;
            $display("FAIL midreset_state: rdy=%b vld=%b res=%h cout=%b required 1 0 0 0",
                     in_ready, out_valid, result_o, cout_o);
        end
        a = $urandom; b = $urandom;
        exp = ref_sum(a, b);
        rst_n    = 1'b1;
        in_valid = 1'b1;
        sum_i    = a;
        carry_i  = b;
        tick();
        in_valid = 1'b0;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL midreset_accept: in_ready=%b required 0", in_ready);
        end
        wait_valid(cyc);
        tests++;
        if (cyc != LAT || {cout_o, result_o} !== exp) begin
            fails++;
            $display("FAIL midreset_after: cyc=%0d got %b_%h required %0d %b_%h", cyc, cout_o, result_o,
                     LAT, exp[WIDTH], exp[WIDTH-1:0]);
        end
        tick();
    endtask

    task automatic test_random();
        logic [WIDTH:0] q[$];
        int got;
        int budget;
        bit prod_ok;
        got = 0;
        prod_ok = 1'b1;
        fork
            begin
                for (int n = 0; n < NRAND && prod_ok; n++) begin
                    logic [WIDTH-1:0] a, b;
                    int w;
                    a = $urandom;
                    b = $urandom;
                    if ($urandom_range(0, 3) == 0) begin
                        a = '1;
                        b = WIDTH'($urandom_range(0, 3));
                    end
                    w = 0;
                    while (!in_ready && w < 40) begin
                        tick();
                        w++;
                    end
                    if (!in_ready) prod_ok = 1'b0;
                    else begin
                        in_valid = 1'b1;
                        sum_i    = a;
                        carry_i  = b;
                        q.push_back(ref_sum(a, b));
                        tick();
                        in_valid = 1'b0;
                        sum_i    = $urandom;
                        carry_i  = $urandom;
                        repeat ($urandom_range(0, 2)) tick();
                    end
                end
            end
            begin
                budget = 0;
                while (got < NRAND && budget < 90000 && !(!prod_ok && q.size() == 0)) begin
                    tick();
                    budget++;
                    out_ready = ($urandom_range(0, 2) != 0);
                    if (out_valid && out_ready) begin
                        tests++;
                        if (q.size() == 0) begin
                            fails++;
                            $display("FAIL rand_dup: result %h with nothing outstanding", result_o);
                        end else begin
                            if ({cout_o, result_o} !== q[0]) begin
                                fails++;
                                $display("FAIL rand_result: #%0d got %b_%h required %b_%h", got, cout_o, result_o,
                                         q[0][WIDTH], q[0][WIDTH-1:0]);
                            end
                            void'(q.pop_front());
                        end
                        got++;
                    end
                end
            end
        join
        tests++;
        if (got != NRAND || q.size() != 0 || !prod_ok) begin
            fails++;
            $display("FAIL rand_count: received %0d left %0d producer_ok %0d required %0d 0 1",
                     got, q.size(), prod_ok, NRAND);
        end
        out_ready = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_ignore_busy();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
